// File: rtl/vga_blink_scheduler.sv
// Frame-synchronous colour/blink sequencer for the 3-bit VGA pixel path.
// Optional colour-cycle mode is built only when VGA_SCHED_CYCLE_EN is defined.
module vga_blink_scheduler #(
    parameter int CNT_W   = 8,
    parameter int DEF_ON  = 30,
    parameter int DEF_OFF = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             in_display,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [2:0]       cfg_color,
    input  logic [CNT_W-1:0] cfg_on,
    input  logic [CNT_W-1:0] cfg_off,
    output logic [2:0]       pixel,
    output logic             phase_on,
    output logic [CNT_W-1:0] frame_cnt
);
    typedef enum logic [2:0] {
        ST_DARK, ST_SOLID, ST_BLINK_ON, ST_BLINK_OFF, ST_CYCLE
    } state_t;

    localparam logic [1:0]       MODE_SOLID = 2'b00;
    localparam logic [1:0]       MODE_BLINK = 2'b01;
    localparam logic [1:0]       MODE_CYCLE = 2'b10;
    localparam logic [1:0]       MODE_DARK  = 2'b11;
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d, pend_mode_q, pend_mode_d;
    logic [2:0]         color_q, color_d, pend_color_q, pend_color_d;
    logic [CNT_W-1:0]   on_q, on_d, pend_on_q, pend_on_d;
    logic [CNT_W-1:0]   off_q, off_d, pend_off_q, pend_off_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               pend_valid_q, pend_valid_d;
    logic [2:0]         pixel_q, pixel_d;
    logic [2:0]         cidx_q, cidx_d;
    logic [2:0]         src;
    logic [CNT_W-1:0]   on_lim, off_lim;
    logic               commit;

    // Zero lengths behave as one frame, so the terminal count is 0 either way.
    assign on_lim  = (on_q  == '0) ? '0 : on_q  - ONE;
    assign off_lim = (off_q == '0) ? '0 : off_q - ONE;
    assign commit  = frame_tick && pend_valid_q;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        color_d      = color_q;
        on_d         = on_q;
        off_d        = off_q;
        pend_mode_d  = pend_mode_q;
        pend_color_d = pend_color_q;
        pend_on_d    = pend_on_q;
        pend_off_d   = pend_off_q;
        pend_valid_d = pend_valid_q;
        frame_cnt_d  = frame_cnt_q;
        cidx_d       = cidx_q;

        if (cfg_valid && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_mode_d  = cfg_mode;
            pend_color_d = cfg_color;
            pend_on_d    = cfg_on;
            pend_off_d   = cfg_off;
        end

        if (commit) begin
            pend_valid_d = 1'b0;
            mode_d       = pend_mode_q;
            color_d      = pend_color_q;
            on_d         = pend_on_q;
            off_d        = pend_off_q;
            frame_cnt_d  = '0;
            case (pend_mode_q)
                MODE_SOLID: state_d = ST_SOLID;
                MODE_BLINK: state_d = ST_BLINK_ON;
`ifdef VGA_SCHED_CYCLE_EN
                MODE_CYCLE: begin
                    state_d = ST_CYCLE;
                    cidx_d  = (pend_color_q == 3'd0) ? 3'd1 : pend_color_q;
                end
`else
                MODE_CYCLE: state_d = ST_SOLID;
`endif
                MODE_DARK:  state_d = ST_DARK;
                default:    state_d = ST_DARK;
            endcase
        end else if (frame_tick) begin
            case (state_q)
                ST_BLINK_ON: begin
                    if (frame_cnt_q == on_lim) begin
                        state_d     = ST_BLINK_OFF;
                        frame_cnt_d = '0;
                    end else frame_cnt_d = frame_cnt_q + ONE;
                end
                ST_BLINK_OFF: begin
                    if (frame_cnt_q == off_lim) begin
                        state_d     = ST_BLINK_ON;
                        frame_cnt_d = '0;
                    end else frame_cnt_d = frame_cnt_q + ONE;
                end
`ifdef VGA_SCHED_CYCLE_EN
                ST_CYCLE: begin
                    if (frame_cnt_q == on_lim) begin
                        cidx_d      = (cidx_q == 3'd7) ? 3'd1 : cidx_q + 3'd1;
                        frame_cnt_d = '0;
                    end else frame_cnt_d = frame_cnt_q + ONE;
                end
`endif
                default: frame_cnt_d = '0;
            endcase
        end

        case (state_q)
            ST_SOLID, ST_BLINK_ON: src = color_q;
`ifdef VGA_SCHED_CYCLE_EN
            ST_CYCLE:              src = cidx_q;
`endif
            default:               src = 3'b000;
        endcase
        pixel_d = in_display ? src : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_DARK;
            mode_q       <= MODE_DARK;
            color_q      <= 3'b111;
            on_q         <= CNT_W'(DEF_ON);
            off_q        <= CNT_W'(DEF_OFF);
            pend_mode_q  <= MODE_DARK;
            pend_color_q <= 3'b000;
            pend_on_q    <= '0;
            pend_off_q   <= '0;
            pend_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
            cidx_q       <= 3'd1;
            pixel_q      <= 3'b000;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            color_q      <= color_d;
            on_q         <= on_d;
            off_q        <= off_d;
            pend_mode_q  <= pend_mode_d;
            pend_color_q <= pend_color_d;
            pend_on_q    <= pend_on_d;
            pend_off_q   <= pend_off_d;
            pend_valid_q <= pend_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            cidx_q       <= cidx_d;
            pixel_q      <= pixel_d;
        end
    end

    assign cfg_ready = !pend_valid_q;
    assign phase_on  = (state_q == ST_SOLID) || (state_q == ST_BLINK_ON) ||
                       (state_q == ST_CYCLE);
    assign pixel     = pixel_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_vga_blink_scheduler.sv
// Directed bench for vga_blink_scheduler: reset, solid, blink, zero lengths,
// transfer-on-tick, colour cycle (or its solid fallback) and mid-run reset.
module tb_vga_blink_scheduler;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset, frame_tick, in_display, cfg_valid, cfg_ready;
    logic [1:0]       cfg_mode;
    logic [2:0]       cfg_color, pixel;
    logic [CNT_W-1:0] cfg_on, cfg_off, frame_cnt;
    logic             phase_on;

    int n_cmp = 0;
    int n_bad = 0;

    vga_blink_scheduler #(.CNT_W(CNT_W), .DEF_ON(30), .DEF_OFF(30)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .in_display(in_display),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_color(cfg_color), .cfg_on(cfg_on), .cfg_off(cfg_off),
        .pixel(pixel), .phase_on(phase_on), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tick edge, then one plain cycle so pixel reflects the new state.
    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic xfer(input logic [1:0] m, input logic [2:0] c,
                        input logic [CNT_W-1:0] on, input logic [CNT_W-1:0] off);
        chk("ready_before_xfer", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_mode = m; cfg_color = c; cfg_on = on; cfg_off = off;
        step();
        cfg_valid = 1'b0;
        chk("ready_after_xfer", cfg_ready, 0);
    endtask

    initial begin
        logic [2:0] cyc_exp [8];
        int k;
        reset = 1'b1; frame_tick = 1'b0; in_display = 1'b1; cfg_valid = 1'b0;
        cfg_mode = 2'b00; cfg_color = 3'b000; cfg_on = '0; cfg_off = '0;
        step(); step();
        chk("rst_pixel", pixel, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_phase", phase_on, 0);
        chk("rst_cnt", frame_cnt, 0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            frame();
            chk("dark_pixel", pixel, 0);
            chk("dark_ready", cfg_ready, 1);
            chk("dark_phase", phase_on, 0);
        end

        // Solid 101
        xfer(2'b00, 3'b101, 8'd0, 8'd0);
        step(); step();
        chk("solid_ready_wait", cfg_ready, 0);
        chk("solid_pre_pixel", pixel, 0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("solid_ready_back", cfg_ready, 1);
        chk("solid_phase", phase_on, 1);
        step();
        chk("solid_pixel_on", pixel, 3'b101);
        in_display = 1'b0; step();
        chk("solid_pixel_blank", pixel, 0);
        in_display = 1'b1; step();
        chk("solid_pixel_on2", pixel, 3'b101);

        // Blink on=2 off=3
        xfer(2'b01, 3'b111, 8'd2, 8'd3);
        frame();
        chk("blink_phase0", phase_on, 1);
        chk("blink_cnt0", frame_cnt, 0);
        chk("blink_pix0", pixel, 3'b111);
        frame(); chk("blink_phase1", phase_on, 1); chk("blink_cnt1", frame_cnt, 1);
        frame(); chk("blink_phase2", phase_on, 0); chk("blink_pix2", pixel, 0);
        frame(); chk("blink_phase3", phase_on, 0); chk("blink_cnt3", frame_cnt, 1);
        frame(); chk("blink_phase4", phase_on, 0); chk("blink_cnt4", frame_cnt, 2);
        chk("blink_pix4", pixel, 0);
        frame(); chk("blink_phase5", phase_on, 1); chk("blink_cnt5", frame_cnt, 0);
        chk("blink_pix5", pixel, 3'b111);

        // Zero lengths toggle every tick
        xfer(2'b01, 3'b010, 8'd0, 8'd0);
        frame(); chk("zero_phase0", phase_on, 1);
        frame(); chk("zero_phase1", phase_on, 0);
        frame(); chk("zero_phase2", phase_on, 1);
        frame(); chk("zero_phase3", phase_on, 0);
        chk("zero_cnt", frame_cnt, 0);

        // Transfer coincident with tick: old blink advances, commit waits
        cfg_valid = 1'b1; cfg_mode = 2'b00; cfg_color = 3'b011;
        frame_tick = 1'b1;
        step();
        cfg_valid = 1'b0; frame_tick = 1'b0;
        chk("tick_xfer_ready", cfg_ready, 0);
        chk("tick_xfer_phase", phase_on, 1);
        step();
        chk("tick_xfer_old_pix", pixel, 3'b010);
        frame();
        chk("tick_xfer_new_pix", pixel, 3'b011);
        chk("tick_xfer_ready2", cfg_ready, 1);

        // Colour cycle from colour 0, one step per frame
        xfer(2'b10, 3'b000, 8'd1, 8'd0);
`ifdef VGA_SCHED_CYCLE_EN
        cyc_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
`else
        cyc_exp = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`endif
        for (k = 0; k < 8; k++) begin
            frame();
            chk($sformatf("cycle_pix%0d", k), pixel, cyc_exp[k]);
            chk($sformatf("cycle_phase%0d", k), phase_on, 1);
        end

        // Reset mid-run discards a pending word
        xfer(2'b00, 3'b110, 8'd0, 8'd0);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_rst_ready", cfg_ready, 1);
        chk("mid_rst_pixel", pixel, 0);
        chk("mid_rst_phase", phase_on, 0);
        frame();
        chk("mid_rst_no_commit", phase_on, 0);
        chk("mid_rst_pixel2", pixel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
